soric_dbus_bank_arbiter: RTL and testbench

- Data-bus interconnect between the core data ports and the SRAM banks' RW ports (port 0).
- Decodes each master address to a bank and arbitrates per bank with round-robin.
- Drives the SRAM control pins (csb, web, wmask, addr, din) and routes read data back with OBI-style gnt/rvalid timing.
- Sits between the two cores and the four sky130 2 kB macros in the soric SoC.

---
 rtl/soric_dbus_bank_arbiter.sv | 164 ++++++++++++++++
 tb/tb_soric_dbus_bank_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/soric_dbus_bank_arbiter.sv
// rtl/soric_dbus_bank_arbiter.sv - core data bus to SRAM bank arbiter, per-bank round-robin
// Optional SORIC_DBUS_CONFLICT_CNT_EN adds per-bank conflict counters.
module soric_dbus_bank_arbiter #(
  parameter int          NCORE       = 2,
  parameter int          NSRAM       = 4,
  parameter int          D_ADDR_W    = 14,
  parameter int          SRAM_ADDR_W = 11,
  parameter logic [31:0] OOR_RDATA   = 32'h0000_0000
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NCORE-1:0]                 m_req_i,
  input  logic [NCORE*D_ADDR_W-1:0]        m_addr_i,
  input  logic [NCORE-1:0]                 m_we_i,
  input  logic [NCORE*4-1:0]               m_be_i,
  input  logic [NCORE*32-1:0]              m_wdata_i,
  output logic [NCORE-1:0]                 m_gnt_o,
  output logic [NCORE-1:0]                 m_rvalid_o,
  output logic [NCORE*32-1:0]              m_rdata_o,
`ifdef SORIC_DBUS_CONFLICT_CNT_EN
  input  logic                             conflict_clr_i,
  output logic [NSRAM*16-1:0]              conflict_cnt_o,
`endif
  output logic [NSRAM-1:0]                 s_csb_o,
  output logic [NSRAM-1:0]                 s_web_o,
  output logic [NSRAM*4-1:0]               s_wmask_o,
  output logic [NSRAM*(SRAM_ADDR_W-2)-1:0] s_addr_o,
  output logic [NSRAM*32-1:0]              s_din_o,
  input  logic [NSRAM*32-1:0]              s_dout_i
);

  localparam int BANK_W  = $clog2(NSRAM);
  localparam int RR_W    = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam int WADDR_W = SRAM_ADDR_W - 2;

  logic [NCORE-1:0]             oor;
  logic [BANK_W-1:0]            bank    [NCORE];
  logic [WADDR_W-1:0]           waddr   [NCORE];
  logic [NSRAM-1:0][NCORE-1:0]  cand;
  logic [NSRAM-1:0][NCORE-1:0]  sel;
  logic [NSRAM-1:0]             bank_act;
  logic [RR_W-1:0]              sel_idx [NSRAM];
  logic [RR_W-1:0]              rr_q    [NSRAM];
  logic [NCORE-1:0]             gnt;
  logic [NCORE-1:0]             rvalid_q;
  logic [NCORE-1:0]             oor_q;
  logic [NCORE-1:0]             we_q;
  logic [BANK_W-1:0]            bank_q  [NCORE];

  for (genvar k = 0; k < NCORE; k++) begin : g_dec
    logic [D_ADDR_W-1:0] a;
    logic                lsb_unused;
    assign a          = m_addr_i[k*D_ADDR_W +: D_ADDR_W];
    assign bank[k]    = a[SRAM_ADDR_W +: BANK_W];
    assign waddr[k]   = a[SRAM_ADDR_W-1:2];
    assign oor[k]     = (a >> (SRAM_ADDR_W + BANK_W)) != '0;
    assign lsb_unused = ^a[1:0];
    for (genvar b = 0; b < NSRAM; b++) begin : g_cand
      assign cand[b][k] = m_req_i[k] & ~oor[k] & ~rst_i & (bank[k] == BANK_W'(b));
    end
  end

  // Scan candidates starting at the pointer; the first hit wins the bank.
  always_comb begin
    logic hit;
    int   idx;
    sel      = '0;
    bank_act = '0;
    hit      = 1'b0;
    idx      = 0;
    for (int b = 0; b < NSRAM; b++) begin
      sel_idx[b] = '0;
      hit        = 1'b0;
      for (int i = 0; i < NCORE; i++) begin
        idx = (int'(rr_q[b]) + i) % NCORE;
        if (!hit && cand[b][idx]) begin
          hit          = 1'b1;
          sel[b][idx]  = 1'b1;
          sel_idx[b]   = RR_W'(idx);
        end
      end
      bank_act[b] = hit;
    end
  end

  always_comb begin
    gnt = m_req_i & oor & {NCORE{~rst_i}};
    for (int b = 0; b < NSRAM; b++) gnt = gnt | sel[b];
  end
  assign m_gnt_o = gnt;

  always_comb begin
    int k;
    s_csb_o   = '1;
    s_web_o   = '1;
    s_wmask_o = '0;
    s_addr_o  = '0;
    s_din_o   = '0;
    k         = 0;
    for (int b = 0; b < NSRAM; b++) begin
      if (bank_act[b]) begin
        k                                 = int'(sel_idx[b]);
        s_csb_o[b]                        = 1'b0;
        s_web_o[b]                        = ~m_we_i[k];
        s_wmask_o[b*4 +: 4]               = m_be_i[k*4 +: 4];
        s_addr_o[b*WADDR_W +: WADDR_W]    = waddr[k];
        s_din_o[b*32 +: 32]               = m_wdata_i[k*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= '0;
      oor_q    <= '0;
      we_q     <= '0;
      for (int b = 0; b < NSRAM; b++) rr_q[b] <= '0;
      for (int k = 0; k < NCORE; k++) bank_q[k] <= '0;
    end else begin
      rvalid_q <= gnt;
      for (int b = 0; b < NSRAM; b++)
        if (bank_act[b]) rr_q[b] <= RR_W'((int'(sel_idx[b]) + 1) % NCORE);
      for (int k = 0; k < NCORE; k++) begin
        if (gnt[k]) begin
          bank_q[k] <= bank[k];
          oor_q[k]  <= oor[k];
          we_q[k]   <= m_we_i[k];
        end
      end
    end
  end

  // Writes still get an rvalid so masters see one response per grant.
  always_comb begin
    for (int k = 0; k < NCORE; k++) begin
      m_rdata_o[k*32 +: 32] = '0;
      if (rvalid_q[k]) begin
        if (oor_q[k])    m_rdata_o[k*32 +: 32] = OOR_RDATA;
        else if (!we_q[k]) m_rdata_o[k*32 +: 32] = s_dout_i[int'(bank_q[k])*32 +: 32];
      end
    end
  end
  assign m_rvalid_o = rvalid_q;

`ifdef SORIC_DBUS_CONFLICT_CNT_EN
  logic [15:0] cnt_q [NSRAM];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < NSRAM; b++) cnt_q[b] <= '0;
    end else if (conflict_clr_i) begin
      for (int b = 0; b < NSRAM; b++) cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < NSRAM; b++)
        if ($countones(cand[b]) >= 2 && cnt_q[b] != 16'hFFFF) cnt_q[b] <= cnt_q[b] + 16'd1;
    end
  end

  for (genvar b = 0; b < NSRAM; b++) begin : g_cnt
    assign conflict_cnt_o[b*16 +: 16] = cnt_q[b];
  end
`endif

endmodule

// File: tb/tb_soric_dbus_bank_arbiter.sv
// tb/tb_soric_dbus_bank_arbiter.sv - vector table plus response scoreboard for the bank arbiter
module tb_soric_dbus_bank_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [27:0]  addr;
  logic [1:0]   we;
  logic [7:0]   be;
  logic [63:0]  wdata;
  logic [1:0]   gnt;
  logic [1:0]   rvalid;
  logic [63:0]  rdata;
  logic [3:0]   csb;
  logic [3:0]   web;
  logic [15:0]  wmask;
  logic [35:0]  saddr;
  logic [127:0] din;
  logic [127:0] dout;
`ifdef SORIC_DBUS_CONFLICT_CNT_EN
  logic         clr;
  logic [63:0]  cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  soric_dbus_bank_arbiter dut (
    .clk_i(clk), .rst_i(rst), .m_req_i(req), .m_addr_i(addr), .m_we_i(we),
    .m_be_i(be), .m_wdata_i(wdata), .m_gnt_o(gnt), .m_rvalid_o(rvalid),
    .m_rdata_o(rdata),
`ifdef SORIC_DBUS_CONFLICT_CNT_EN
    .conflict_clr_i(clr), .conflict_cnt_o(cnt),
`endif
    .s_csb_o(csb), .s_web_o(web), .s_wmask_o(wmask), .s_addr_o(saddr),
    .s_din_o(din), .s_dout_i(dout)
  );

  typedef struct {
    logic [1:0]  req;
    logic [13:0] a0, a1;
    logic [1:0]  we;
    logic [3:0]  be0, be1;
    logic [31:0] wd0, wd1;
    logic [1:0]  gnt;
    logic [3:0]  csb, web;
    int          cb;
    logic [8:0]  ad;
    logic [3:0]  wm;
    logic [31:0] dn;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int          due;
  } rsp_t;

  rsp_t sbq0[$];
  rsp_t sbq1[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endfunction

  function automatic logic [31:0] pat(input logic [1:0] b);
    return 32'h1111_1111 * (32'(b) + 32'd1);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [13:0] a, input logic w);
    if (a[13]) return 32'h0000_0000;
    if (w) return 32'h0;
    return pat(a[12:11]);
  endfunction

  function automatic vec_t mk(input logic [1:0] rq, input logic [13:0] a0, input logic [13:0] a1,
                              input logic [1:0] w, input logic [3:0] be0, input logic [3:0] be1,
                              input logic [31:0] wd0, input logic [31:0] wd1, input logic [1:0] g,
                              input logic [3:0] cs, input logic [3:0] wb, input int cb,
                              input logic [8:0] ad, input logic [3:0] wm, input logic [31:0] dn);
    vec_t v;
    v.req = rq; v.a0 = a0; v.a1 = a1; v.we = w; v.be0 = be0; v.be1 = be1;
    v.wd0 = wd0; v.wd1 = wd1; v.gnt = g; v.csb = cs; v.web = wb;
    v.cb = cb; v.ad = ad; v.wm = wm; v.dn = dn;
    return v;
  endfunction

  // Response checker: rvalid must appear exactly on the cycle recorded at grant time.
  always @(negedge clk) begin : mon
    rsp_t e;
    logic exp_rv;
    for (int m = 0; m < 2; m++) begin
      exp_rv  = 1'b0;
      e.rdata = '0;
      e.due   = 0;
      if (m == 0 && sbq0.size() > 0 && sbq0[0].due == cyc) begin
        exp_rv = 1'b1;
        e      = sbq0.pop_front();
      end else if (m == 1 && sbq1.size() > 0 && sbq1[0].due == cyc) begin
        exp_rv = 1'b1;
        e      = sbq1.pop_front();
      end
      chk($sformatf("rvalid%0d_c%0d", m, cyc), 32'(rvalid[m]), 32'(exp_rv));
      if (exp_rv && rvalid[m]) chk($sformatf("rdata%0d_c%0d", m, cyc), rdata[m*32 +: 32], e.rdata);
    end
  end

  task automatic apply(input vec_t v, input int n);
    rsp_t r;
    req   = v.req;
    addr  = {v.a1, v.a0};
    we    = v.we;
    be    = {v.be1, v.be0};
    wdata = {v.wd1, v.wd0};
    @(negedge clk);
    chk($sformatf("v%0d_gnt", n), 32'(gnt), 32'(v.gnt));
    chk($sformatf("v%0d_csb", n), 32'(csb), 32'(v.csb));
    chk($sformatf("v%0d_web", n), 32'(web), 32'(v.web));
    if (v.cb >= 0) begin
      chk($sformatf("v%0d_addr", n), 32'(saddr[v.cb*9 +: 9]), 32'(v.ad));
      chk($sformatf("v%0d_wmask", n), 32'(wmask[v.cb*4 +: 4]), 32'(v.wm));
      chk($sformatf("v%0d_din", n), din[v.cb*32 +: 32], v.dn);
    end
    r.due = cyc + 1;
    if (v.gnt[0]) begin
      r.rdata = exp_rd(v.a0, v.we[0]);
      sbq0.push_back(r);
    end
    if (v.gnt[1]) begin
      r.rdata = exp_rd(v.a1, v.we[1]);
      sbq1.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vt[$];
  vec_t idle;

  initial begin
    rst   = 1'b1;
    req   = 2'b11;
    addr  = {14'h0000, 14'h0804};
    we    = 2'b00;
    be    = 8'hFF;
    wdata = '0;
    dout  = {pat(2'd3), pat(2'd2), pat(2'd1), pat(2'd0)};
`ifdef SORIC_DBUS_CONFLICT_CNT_EN
    clr   = 1'b0;
`endif
    idle = mk(2'b00, 14'h0, 14'h0, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 4'b1111, 4'b1111, 0, 9'd0, 4'h0, 32'h0);

    vt.push_back(mk(2'b01, 14'h0804, 14'h0000, 2'b00, 4'hF, 4'h0, 32'h0, 32'h0, 2'b01, 4'b1101, 4'b1111, 1, 9'd1, 4'hF, 32'h0));
    vt.push_back(mk(2'b10, 14'h0000, 14'h1000, 2'b10, 4'h0, 4'b0011, 32'h0, 32'hCAFEF00D, 2'b10, 4'b1011, 4'b1011, 2, 9'd0, 4'b0011, 32'hCAFEF00D));
    vt.push_back(mk(2'b11, 14'h0000, 14'h0010, 2'b00, 4'hF, 4'hF, 32'h0, 32'h0, 2'b01, 4'b1110, 4'b1111, 0, 9'd0, 4'hF, 32'h0));
    vt.push_back(mk(2'b11, 14'h0020, 14'h0010, 2'b00, 4'hF, 4'hF, 32'h0, 32'h0, 2'b10, 4'b1110, 4'b1111, 0, 9'd4, 4'hF, 32'h0));
    vt.push_back(mk(2'b11, 14'h0020, 14'h0030, 2'b00, 4'hF, 4'hF, 32'h0, 32'h0, 2'b01, 4'b1110, 4'b1111, 0, 9'd8, 4'hF, 32'h0));
    vt.push_back(mk(2'b11, 14'h0040, 14'h0030, 2'b00, 4'hF, 4'hF, 32'h0, 32'h0, 2'b10, 4'b1110, 4'b1111, 0, 9'd12, 4'hF, 32'h0));
    vt.push_back(mk(2'b11, 14'h0040, 14'h1FF8, 2'b10, 4'hF, 4'b1100, 32'h0, 32'h12345678, 2'b11, 4'b0110, 4'b0111, 3, 9'd510, 4'b1100, 32'h12345678));
    vt.push_back(mk(2'b01, 14'h2000, 14'h0000, 2'b00, 4'hF, 4'h0, 32'h0, 32'h0, 2'b01, 4'b1111, 4'b1111, -1, 9'd0, 4'h0, 32'h0));
    vt.push_back(mk(2'b11, 14'h3FFC, 14'h0FFC, 2'b00, 4'hF, 4'hF, 32'h0, 32'h0, 2'b11, 4'b1101, 4'b1111, 1, 9'd511, 4'hF, 32'h0));
    vt.push_back(idle);
    vt.push_back(mk(2'b11, 14'h1004, 14'h1008, 2'b11, 4'b0001, 4'b1000, 32'hAAAA0001, 32'hBBBB0002, 2'b01, 4'b1011, 4'b1011, 2, 9'd1, 4'b0001, 32'hAAAA0001));
    vt.push_back(mk(2'b10, 14'h0000, 14'h1008, 2'b10, 4'h0, 4'b1000, 32'h0, 32'hBBBB0002, 2'b10, 4'b1011, 4'b1011, 2, 9'd2, 4'b1000, 32'hBBBB0002));
    vt.push_back(mk(2'b11, 14'h0808, 14'h080C, 2'b00, 4'hF, 4'hF, 32'h0, 32'h0, 2'b01, 4'b1101, 4'b1111, 1, 9'd2, 4'hF, 32'h0));
    vt.push_back(mk(2'b11, 14'h0810, 14'h080C, 2'b00, 4'hF, 4'hF, 32'h0, 32'h0, 2'b10, 4'b1101, 4'b1111, 1, 9'd3, 4'hF, 32'h0));
    vt.push_back(mk(2'b01, 14'h0810, 14'h0000, 2'b00, 4'hF, 4'h0, 32'h0, 32'h0, 2'b01, 4'b1101, 4'b1111, 1, 9'd4, 4'hF, 32'h0));
    vt.push_back(idle);

    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata0", rdata[31:0], 32'h0);
    chk("rst_rdata1", rdata[63:32], 32'h0);
    chk("rst_csb", 32'(csb), 32'hF);
    chk("rst_web", 32'(web), 32'hF);
    chk("rst_wmask", 32'(wmask), 32'h0);
    chk("rst_addr", 32'(saddr[31:0]) | 32'(saddr[35:32]), 32'h0);
    chk("rst_din", din[31:0] | din[63:32] | din[95:64] | din[127:96], 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    req = 2'b00;
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Reset one cycle after a grant: pending response must vanish and the pointer clear.
    apply(mk(2'b01, 14'h0004, 14'h0000, 2'b00, 4'hF, 4'h0, 32'h0, 32'h0, 2'b01, 4'b1110, 4'b1111, 0, 9'd1, 4'hF, 32'h0), 100);
    rst = 1'b1;
    sbq0.delete();
    sbq1.delete();
    #1;
    chk("midrst_rvalid", 32'(rvalid), 32'h0);
    chk("midrst_rdata", rdata[31:0], 32'h0);
    chk("midrst_csb", 32'(csb), 32'hF);
    chk("midrst_gnt", 32'(gnt), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(mk(2'b11, 14'h0000, 14'h0010, 2'b00, 4'hF, 4'hF, 32'h0, 32'h0, 2'b01, 4'b1110, 4'b1111, 0, 9'd0, 4'hF, 32'h0), 101);
    apply(mk(2'b11, 14'h0020, 14'h0010, 2'b00, 4'hF, 4'hF, 32'h0, 32'h0, 2'b10, 4'b1110, 4'b1111, 0, 9'd4, 4'hF, 32'h0), 102);
    apply(idle, 103);

`ifdef SORIC_DBUS_CONFLICT_CNT_EN
    clr = 1'b1;
    apply(idle, 200);
    clr = 1'b0;
    chk("cnt_clr", cnt[15:0], 32'h0);
    apply(mk(2'b11, 14'h0000, 14'h0010, 2'b00, 4'hF, 4'hF, 32'h0, 32'h0, 2'b01, 4'b1110, 4'b1111, 0, 9'd0, 4'hF, 32'h0), 201);
    apply(mk(2'b11, 14'h0020, 14'h0010, 2'b00, 4'hF, 4'hF, 32'h0, 32'h0, 2'b10, 4'b1110, 4'b1111, 0, 9'd4, 4'hF, 32'h0), 202);
    apply(mk(2'b11, 14'h0020, 14'h0030, 2'b00, 4'hF, 4'hF, 32'h0, 32'h0, 2'b01, 4'b1110, 4'b1111, 0, 9'd8, 4'hF, 32'h0), 203);
    chk("cnt_bank0", 32'(cnt[15:0]), 32'd3);
    chk("cnt_bank1", 32'(cnt[31:16]), 32'd0);
    apply(idle, 204);
`endif

    apply(idle, 300);
    chk("sb_drained", 32'(sbq0.size() + sbq1.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
